// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: shared types for the fetch/LSU memory port arbiter.
// Rev 1.0
package mem_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [3:0] c_INSTR_BE = 4'hF;

  // Fetches are always full-word reads.
  function automatic bus_req_t instr_bus_req(input logic [31:0] addr);
    bus_req_t r;
    r.addr  = addr;
    r.we    = 1'b0;
    r.be    = c_INSTR_BE;
    r.wdata = '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_owner_fifo.sv
`default_nettype none
// arb_owner_fifo: in-order record of which requester owns each outstanding transaction.
// Rev 1.0
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   push_i,
  input  owner_e push_owner_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_e head_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);

  logic [(2**PW)-1:0] entries_q;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == PW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = owner_e'(entries_q[rd_ptr_q]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (do_push) entries_q[wr_ptr_q] <= push_owner_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one memory port between fetch and LSU, routing responses in grant order.
// Rev 1.0
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit ROUND_ROBIN     = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_valid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  owner_e   sel, head, locked_owner_q, locked_owner_d, last_grant_q, last_grant_d;
  logic     lock_q, lock_d;
  logic     sel_req, fifo_full, fifo_empty, accept, stall, rsp_valid;
  bus_req_t instr_bus, data_bus, sel_bus;

  assign instr_bus = instr_bus_req(instr_addr_i);
  assign data_bus  = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};

  // A stalled request keeps ownership so its address stays stable until granted.
  always_comb begin
    sel = data_req_i ? OWNER_DATA : OWNER_INSTR;
    if (lock_q)
      sel = locked_owner_q;
    else if (ROUND_ROBIN && instr_req_i && data_req_i)
      sel = (last_grant_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
  end

  assign sel_req   = (sel == OWNER_DATA) ? data_req_i : instr_req_i;
  assign sel_bus   = (sel == OWNER_DATA) ? data_bus : instr_bus;
  assign mem_req_o = ~reset_i & sel_req & ~fifo_full;
  assign accept    = mem_req_o & mem_gnt_i;
  assign stall     = mem_req_o & ~mem_gnt_i;

  assign mem_addr_o  = reset_i ? '0 : sel_bus.addr;
  assign mem_we_o    = reset_i ? 1'b0 : sel_bus.we;
  assign mem_be_o    = reset_i ? '0 : sel_bus.be;
  assign mem_wdata_o = reset_i ? '0 : sel_bus.wdata;

  assign instr_gnt_o = accept & (sel == OWNER_INSTR);
  assign data_gnt_o  = accept & (sel == OWNER_DATA);

  assign rsp_valid     = ~reset_i & mem_valid_i & ~fifo_empty;
  assign instr_valid_o = rsp_valid & (head == OWNER_INSTR);
  assign data_valid_o  = rsp_valid & (head == OWNER_DATA);
  assign instr_rdata_o = instr_valid_o ? mem_rdata_i : '0;
  assign data_rdata_o  = data_valid_o ? mem_rdata_i : '0;
  assign instr_err_o   = instr_valid_o & mem_err_i;
  assign data_err_o    = data_valid_o & mem_err_i;

  always_comb begin
    lock_d         = lock_q;
    locked_owner_d = locked_owner_q;
    last_grant_d   = last_grant_q;
    if (accept) begin
      lock_d       = 1'b0;
      last_grant_d = sel;
    end else if (stall) begin
      lock_d         = 1'b1;
      locked_owner_d = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q         <= 1'b0;
      locked_owner_q <= OWNER_INSTR;
      last_grant_q   <= OWNER_INSTR;
    end else begin
      lock_q         <= lock_d;
      locked_owner_q <= locked_owner_d;
      last_grant_q   <= last_grant_d;
    end
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (accept),
    .push_owner_i(sel),
    .pop_i       (mem_valid_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (reset_i) mem_valid_i |-> !fifo_empty)
    else $error("mem_valid with no outstanding transaction");

endmodule
`default_nettype wire
